// File: rtl/fifo_wr_arbiter_pkg.sv
// rtl/fifo_wr_arbiter_pkg.sv - shared state encoding and FIFO word layout for fifo_wr_arbiter
package fifo_wr_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    DISCARD = 2'd2
  } arbState_t;

  // FIFO word is {id, last, data}; offsets depend only on the payload width.
  localparam int DATA_LSB = 0;

  function automatic int lastBit(input int dataW);
    return dataW;
  endfunction

  function automatic int idLsb(input int dataW);
    return dataW + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - source beat handshake and FIFO write port bundle
interface fifo_wr_arbiter_if #(
  parameter int pN_REQ  = 4,
  parameter int pDATA_W = 8
);
  localparam int pID_W       = $clog2(pN_REQ);
  localparam int pFIFO_WIDTH = pDATA_W + 1 + pID_W;

  logic [pN_REQ-1:0]         ireq_valid;
  logic [pN_REQ-1:0]         ireq_last;
  logic [pN_REQ*pDATA_W-1:0] ireq_data;
  logic [pN_REQ-1:0]         oreq_ready;
  logic                      ififo_full;
  logic                      ofifo_wr;
  logic [pFIFO_WIDTH-1:0]    ofifo_data;

  // master: sources plus FIFO status; slave: the arbiter
  modport master (
    output ireq_valid, ireq_last, ireq_data, ififo_full,
    input  oreq_ready, ofifo_wr, ofifo_data
  );

  modport slave (
    input  ireq_valid, ireq_last, ireq_data, ififo_full,
    output oreq_ready, ofifo_wr, ofifo_data
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin search for the first valid requester
module fifo_wr_arbiter_rr_pick #(
  parameter  int pN_REQ = 4,
  localparam int pID_W  = $clog2(pN_REQ)
) (
  input  logic [pN_REQ-1:0] ireq,
  input  logic [pID_W-1:0]  irrPtr,
  output logic              ofound,
  output logic [pID_W-1:0]  oidx
);

  int                cand;
  logic [pID_W-1:0]  candIdx;

  // Search starts one past the last served source so it gets lowest priority.
  always_comb begin
    ofound  = 1'b0;
    oidx    = '0;
    cand    = 0;
    candIdx = '0;
    for (int i = 1; i <= pN_REQ; i++) begin
      cand    = (int'(irrPtr) + i) % pN_REQ;
      candIdx = pID_W'(cand);
      if (!ofound && ireq[candIdx]) begin
        ofound = 1'b1;
        oidx   = candIdx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - packet-granular round-robin arbiter for the packet FIFO write port
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter  int pN_REQ   = 4,
  parameter  int pDATA_W  = 8,
  parameter  int pMAX_LEN = 64,
  localparam int pID_W    = $clog2(pN_REQ)
) (
  input  logic              iclk,
  input  logic              ireset_n,
  fifo_wr_arbiter_if.slave  bus,
  output logic [pID_W-1:0]  ogrant_id,
  output logic              obusy,
  output logic              oerr_trunc
);

  localparam int pFIFO_WIDTH = pDATA_W + 1 + pID_W;
  localparam int CNT_W       = $clog2(pMAX_LEN + 1);
  localparam int LAST_POS    = lastBit(pDATA_W);
  localparam int ID_LSB      = idLsb(pDATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(pMAX_LEN - 1);

  arbState_t             state, nextState;
  logic [pID_W-1:0]      grant, nextGrant;
  logic [pID_W-1:0]      rrPtr, nextRrPtr;
  logic [CNT_W-1:0]      beatCnt, nextBeatCnt;
  logic                  truncPulse, nextTrunc;

  logic                  pickFound;
  logic [pID_W-1:0]      pickIdx;
  logic                  gValid, gLast, gReady, effLast, accept, atLimit;
  logic [pDATA_W-1:0]    gData;
  logic [pFIFO_WIDTH-1:0] fifoWord;

  fifo_wr_arbiter_rr_pick #(
    .pN_REQ (pN_REQ)
  ) uPick (
    .ireq   (bus.ireq_valid),
    .irrPtr (rrPtr),
    .ofound (pickFound),
    .oidx   (pickIdx)
  );

  always_comb begin
    gValid = 1'b0;
    gLast  = 1'b0;
    gData  = '0;
    for (int k = 0; k < pN_REQ; k++) begin
      if (grant == pID_W'(k)) begin
        gValid = bus.ireq_valid[k];
        gLast  = bus.ireq_last[k];
        gData  = bus.ireq_data[k*pDATA_W +: pDATA_W];
      end
    end
  end

  assign atLimit = (beatCnt == LAST_CNT);
  assign effLast = gLast | atLimit;

  // DISCARD drains the owner regardless of FIFO space since nothing is written.
  always_comb begin
    gReady = 1'b0;
    case (state)
      XFER:    gReady = ~bus.ififo_full;
      DISCARD: gReady = 1'b1;
      default: gReady = 1'b0;
    endcase
  end

  assign accept = gValid & gReady;

  always_comb begin
    bus.oreq_ready = '0;
    for (int k = 0; k < pN_REQ; k++) begin
      bus.oreq_ready[k] = gReady && (grant == pID_W'(k));
    end
  end

  assign bus.ofifo_wr = (state == XFER) & gValid & ~bus.ififo_full;

  always_comb begin
    fifoWord                         = '0;
    fifoWord[DATA_LSB +: pDATA_W]    = gData;
    fifoWord[LAST_POS]               = effLast;
    fifoWord[ID_LSB +: pID_W]        = grant;
  end

  assign bus.ofifo_data = fifoWord;

  always_comb begin
    nextState   = state;
    nextGrant   = grant;
    nextRrPtr   = rrPtr;
    nextBeatCnt = beatCnt;
    nextTrunc   = 1'b0;
    case (state)
      IDLE: begin
        if (pickFound) begin
          nextGrant   = pickIdx;
          nextBeatCnt = '0;
          nextState   = XFER;
        end
      end
      XFER: begin
        if (accept) begin
          nextBeatCnt = beatCnt + CNT_W'(1);
          if (gLast) begin
            nextState = IDLE;
            nextRrPtr = grant;
          end else if (atLimit) begin
            nextState = DISCARD;
            nextTrunc = 1'b1;
          end
        end
      end
      DISCARD: begin
        if (accept && gLast) begin
          nextState = IDLE;
          nextRrPtr = grant;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // A reset mid-packet simply abandons it; the FIFO never sees a forced last.
  always_ff @(posedge iclk) begin
    if (!ireset_n) begin
      state      <= IDLE;
      rrPtr      <= pID_W'(pN_REQ - 1);
      grant      <= '0;
      beatCnt    <= '0;
      truncPulse <= 1'b0;
    end else begin
      state      <= nextState;
      rrPtr      <= nextRrPtr;
      grant      <= nextGrant;
      beatCnt    <= nextBeatCnt;
      truncPulse <= nextTrunc;
    end
  end

  assign ogrant_id  = grant;
  assign obusy      = (state != IDLE);
  assign oerr_trunc = truncPulse;

endmodule
